// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/halt sequencer for the single-cycle MIPS core. Issues a one-clk
//   execute enable (cpu_en), owns the core reset, counts issued enables and
//   stops the core once a cycle budget is used up.
//
// Ports
//   clk        board clock, only clock domain
//   rst        asynchronous active-low reset
//   run_sw     1 = free-run, 0 = stopped (async, synchronized here)
//   step_btn   raw single-step button, active high (async, bouncy)
//   div_sel    run rate: one cpu_en every 2^div_sel clks
//   halt_clr   sync pulse; in HALT re-resets the core and clears the count
//   cpu_en     registered one-clk execute enable
//   cpu_rst    active-high core reset
//   cycle_cnt  cpu_en pulses issued since the last core reset
//   halted     1 while in HALT
//   state_o    FSM state for LEDs
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RSTHOLD  | core held in reset for RST_HOLD clks, count/prescaler zero
// IDLE     | stopped; a debounced step press issues one cpu_en
// RUN      | free-running, one cpu_en every 2^div_sel clks
// HALT     | cycle budget used up; waits for halt_clr
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned CYCLE_LIMIT     = 3072,
  parameter int unsigned RST_HOLD        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [4:0]  div_sel,
  input  logic        halt_clr,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic [31:0] cycle_cnt,
  output logic        halted,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RSTHOLD = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);

  state_t            state;
  logic              run_meta, run_sync;
  logic              step_meta, step_sync;
  logic              db_level, db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       presc;
  logic [31:0]       presc_term;
  logic [31:0]       cnt_inc;
  logic              presc_hit;
  logic              limit_hit;
  logic              step_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_meta  <= 1'b0;
      run_sync  <= 1'b0;
      step_meta <= 1'b0;
      step_sync <= 1'b0;
    end else begin
      run_meta  <= run_sw;
      run_sync  <= run_meta;
      step_meta <= step_btn;
      step_sync <= step_meta;
    end
  end

  // Down-counter reloads on every agreeing cycle, so only an unbroken run of
  // DEBOUNCE_CYCLES mismatching cycles moves the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= DB_LOAD;
    end else begin
      db_prev <= db_level;
      if (step_sync != db_level) begin
        if (db_cnt == '0) begin
          db_level <= step_sync;
          db_cnt   <= DB_LOAD;
        end else begin
          db_cnt <= db_cnt - 1'b1;
        end
      end else begin
        db_cnt <= DB_LOAD;
      end
    end
  end

  assign step_req   = db_level & ~db_prev;
  assign presc_term = (32'd1 << div_sel) - 32'd1;
  assign presc_hit  = (presc == presc_term);
  assign cnt_inc    = cycle_cnt + 32'd1;
  assign limit_hit  = (CYCLE_LIMIT != 0) && (cnt_inc == 32'(CYCLE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RSTHOLD;
      cpu_en    <= 1'b0;
      cpu_rst   <= 1'b1;
      cycle_cnt <= '0;
      halted    <= 1'b0;
      presc     <= '0;
      hold_cnt  <= HOLD_LOAD;
    end else begin
      cpu_en <= 1'b0;
      case (state)
        ST_RSTHOLD: begin
          cycle_cnt <= '0;
          presc     <= '0;
          if (hold_cnt == '0) begin
            state   <= ST_IDLE;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (run_sync) begin
            state <= ST_RUN;
            presc <= '0;
          end else if (step_req) begin
            cpu_en    <= 1'b1;
            cycle_cnt <= cnt_inc;
            if (limit_hit) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // The final budgeted pulse goes out even if run_sw just dropped.
          if (presc_hit && limit_hit) begin
            cpu_en    <= 1'b1;
            cycle_cnt <= cnt_inc;
            presc     <= '0;
            state     <= ST_HALT;
            halted    <= 1'b1;
          end else if (!run_sync) begin
            state <= ST_IDLE;
          end else if (presc_hit) begin
            cpu_en    <= 1'b1;
            cycle_cnt <= cnt_inc;
            presc     <= '0;
          end else if (presc > presc_term) begin
            // div_sel shrank below the current count: restart without a pulse
            presc <= '0;
          end else begin
            presc <= presc + 32'd1;
          end
        end
        ST_HALT: begin
          if (halt_clr) begin
            state     <= ST_RSTHOLD;
            cpu_rst   <= 1'b1;
            halted    <= 1'b0;
            cycle_cnt <= '0;
            presc     <= '0;
            hold_cnt  <= HOLD_LOAD;
          end
        end
        default: state <= ST_RSTHOLD;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (cycle budget 8 and unlimited) share
// stimulus; a clock-by-clock reference model built from the behavioural rules
// predicts every output. Directed scenarios first, then random stimulus.
module tb_cpu_run_ctrl;

  localparam int DEBOUNCE = 20;
  localparam int HOLD     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic [4:0]  div_sel;
  logic        halt_clr;
  logic [1:0]  en_v, crst_v, halt_v;
  logic [31:0] cnt_v [2];
  logic [1:0]  st_v  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CYCLE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .div_sel(div_sel), .halt_clr(halt_clr),
    .cpu_en(en_v[0]), .cpu_rst(crst_v[0]), .cycle_cnt(cnt_v[0]),
    .halted(halt_v[0]), .state_o(st_v[0])
  );

  cpu_run_ctrl #(.CYCLE_LIMIT(0)) dut_nl (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .div_sel(div_sel), .halt_clr(halt_clr),
    .cpu_en(en_v[1]), .cpu_rst(crst_v[1]), .cycle_cnt(cnt_v[1]),
    .halted(halt_v[1]), .state_o(st_v[1])
  );

  // ---------------- reference model ----------------
  // mode values follow the LED encoding: 0 reset-hold, 1 idle, 2 run, 3 halt
  int unsigned     lim [2] = '{8, 0};
  int              m_mode [2];
  int              m_hold [2];
  longint unsigned m_presc [2];
  logic [31:0]     m_cnt [2];
  bit              m_en [2];
  bit              m_rst [2];
  bit              run_hist [2];
  bit              step_hist [2];
  bit              db_level, db_prev;
  int              db_run;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_hold[i] = 0; m_presc[i] = 0;
      m_cnt[i] = 0; m_en[i] = 0; m_rst[i] = 1;
      run_hist[i] = 0; step_hist[i] = 0;
    end
    db_level = 0; db_prev = 0; db_run = 0;
  endtask

  task automatic pulse(input int i);
    m_en[i] = 1;
    m_cnt[i] = m_cnt[i] + 32'd1;
    if (lim[i] != 0 && m_cnt[i] == lim[i]) m_mode[i] = 3;
  endtask

  task automatic model_step();
    bit run_s, step_req, hit, old_level;
    longint unsigned term;
    run_s    = run_hist[1];
    step_req = db_level && !db_prev;
    term     = (64'd1 << div_sel) - 1;
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 0;
      case (m_mode[i])
        0: begin
          m_hold[i]++;
          m_cnt[i] = 0;
          m_presc[i] = 0;
          if (m_hold[i] == HOLD) begin m_mode[i] = 1; m_rst[i] = 0; end
        end
        1: begin
          if (run_s) begin m_mode[i] = 2; m_presc[i] = 0; end
          else if (step_req) pulse(i);
        end
        2: begin
          hit = (m_presc[i] == term);
          if (hit && lim[i] != 0 && m_cnt[i] + 32'd1 == lim[i]) begin
            pulse(i); m_presc[i] = 0;
          end else if (!run_s) m_mode[i] = 1;
          else if (hit) begin pulse(i); m_presc[i] = 0; end
          else if (m_presc[i] > term) m_presc[i] = 0;
          else m_presc[i]++;
        end
        default: begin
          if (halt_clr) begin
            m_mode[i] = 0; m_hold[i] = 0; m_cnt[i] = 0; m_rst[i] = 1;
          end
        end
      endcase
    end
    old_level = db_level;
    if (step_hist[1] != db_level) begin
      db_run++;
      if (db_run == DEBOUNCE) begin db_level = step_hist[1]; db_run = 0; end
    end else begin
      db_run = 0;
    end
    db_prev = old_level;
    run_hist[1]  = run_hist[0];  run_hist[0]  = run_sw;
    step_hist[1] = step_hist[0]; step_hist[0] = step_btn;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cpu_en[%0d]", i),    32'(en_v[i]),   32'(m_en[i]));
      chk($sformatf("cpu_rst[%0d]", i),   32'(crst_v[i]), 32'(m_rst[i]));
      chk($sformatf("cycle_cnt[%0d]", i), cnt_v[i],       m_cnt[i]);
      chk($sformatf("halted[%0d]", i),    32'(halt_v[i]), 32'(m_mode[i] == 3));
      chk($sformatf("state_o[%0d]", i),   32'(st_v[i]),   32'(m_mode[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int pulses;

  initial begin
    rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0; div_sel = 5'd0; halt_clr = 1'b0;
    model_reset();

    // 1: reset release, core reset held 4 clks then IDLE
    reset_dut();
    chk("t1_rst_at_release", 32'(crst_v[0]), 32'd1);
    repeat (3) tick();
    chk("t1_rst_held", 32'(crst_v[0]), 32'd1);
    tick();
    chk("t1_state_idle", 32'(st_v[0]), 32'd1);
    chk("t1_no_en", 32'(en_v[0]), 32'd0);

    // 2: bouncy step press yields exactly one pulse
    for (int b = 0; b < 5; b++) begin
      step_btn = 1'b1; repeat (3) tick();
      step_btn = 1'b0; repeat (3) tick();
    end
    step_btn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin tick(); pulses += int'(en_v[0]); end
    step_btn = 1'b0;
    for (int k = 0; k < 30; k++) begin tick(); pulses += int'(en_v[0]); end
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_cnt", cnt_v[0], 32'd1);

    // 3: free-run at div 2, stop after 10 pulses (unlimited instance)
    reset_dut();
    repeat (HOLD) tick();
    div_sel = 5'd2; run_sw = 1'b1;
    for (int k = 0; k < 300 && cnt_v[1] != 32'd10; k++) tick();
    run_sw = 1'b0;
    repeat (6) tick();
    chk("t3_cnt", cnt_v[1], 32'd10);
    chk("t3_state_idle", 32'(st_v[1]), 32'd1);

    // 4: budget of 8 back-to-back pulses, then halt_clr
    reset_dut();
    div_sel = 5'd0; run_sw = 1'b1;
    pulses = 0;
    for (int k = 0; k < 100 && !halt_v[0]; k++) begin tick(); pulses += int'(en_v[0]); end
    chk("t4_halted", 32'(halt_v[0]), 32'd1);
    chk("t4_pulses", 32'(pulses), 32'd8);
    repeat (3) tick();
    chk("t4_cnt_frozen", cnt_v[0], 32'd8);
    halt_clr = 1'b1; tick(); halt_clr = 1'b0;
    chk("t4_clr_state", 32'(st_v[0]), 32'd0);
    chk("t4_clr_cnt", cnt_v[0], 32'd0);
    chk("t4_clr_rst", 32'(crst_v[0]), 32'd1);

    // 5: unlimited counter wraps past all-ones without halting
    run_sw = 1'b0;
    repeat (6) tick();
    force dut_nl.cycle_cnt = 32'hFFFF_FFFD;
    m_cnt[1] = 32'hFFFF_FFFD;
    tick();
    release dut_nl.cycle_cnt;
    tick();
    run_sw = 1'b1;
    repeat (10) tick();
    chk("t5_no_halt", 32'(halt_v[1]), 32'd0);
    chk("t5_wrapped", 32'(cnt_v[1] < 32'h10), 32'd1);

    // 6: async reset while cpu_en is high
    for (int k = 0; k < 20 && !en_v[1]; k++) tick();
    chk("t6_en_seen", 32'(en_v[1]), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_en_drop", 32'(en_v[1]), 32'd0);
    chk("t6_rst_high", 32'(crst_v[1]), 32'd1);
    chk("t6_cnt_zero", cnt_v[1], 32'd0);
    chk("t6_state", 32'(st_v[1]), 32'd0);
    #2;
    rst = 1'b1;

    // random phase
    run_sw = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if ($urandom_range(0, 59) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 24) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 49) == 0) div_sel = 5'($urandom_range(0, 4));
      halt_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1499) == 0) reset_dut();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
